// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-master RAM arbiter: bus width defaults and master IDs.
// No logic here; imported by mem_arbiter and rr_pick2.
package mem_arbiter_pkg;

  localparam int AW_DEF        = 16;
  localparam int DW_DEF        = 16;
  localparam int MAX_BURST_DEF = 4;

  // NONE marks "no master holds the lock".
  typedef enum logic [1:0] {
    M0   = 2'd0,
    M1   = 2'd1,
    NONE = 2'd2
  } master_e;

  function automatic master_e id_to_master(input logic id);
    return id ? M1 : M0;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick with lock override and burst limit; purely combinational.
// Zero latency; valid whenever any request is present.
module rr_pick2
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BW        = 3
) (
  input  logic [1:0]    i_req,
  input  master_e       i_lock_owner,
  input  logic [BW-1:0] i_burst_cnt,
  input  logic          i_last_grant,
  output logic          o_valid,
  output logic          o_winner
);

  logic w_lock_vld;
  logic w_lock_id;
  logic w_other_id;
  logic w_at_limit;

  assign w_lock_vld = (i_lock_owner != NONE);
  assign w_lock_id  = (i_lock_owner == M1);
  assign w_other_id = ~w_lock_id;
  assign w_at_limit = (i_burst_cnt == BW'(MAX_BURST));

  always_comb begin
    o_valid  = |i_req;
    o_winner = 1'b0;
    if (w_lock_vld && i_req[w_lock_id]) begin
      // The owner keeps the port until its burst budget runs out while the other side waits.
      o_winner = (w_at_limit && i_req[w_other_id]) ? w_other_id : w_lock_id;
    end else begin
      case (i_req)
        2'b01:   o_winner = 1'b0;
        2'b10:   o_winner = 1'b1;
        2'b11:   o_winner = ~i_last_grant;
        default: o_winner = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between two masters: grant and address issue in the request cycle,
// read data returns one cycle later with a per-master valid; a losing request simply waits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic [AW-1:0] memAddr,
  input  logic [DW-1:0] memRead,
  output logic [DW-1:0] memWrite,
  output logic          memWE
);

  localparam int BW = $clog2(MAX_BURST + 1);

  logic          r_last_grant;
  master_e       r_lock_owner;
  logic [BW-1:0] r_burst_cnt;
  logic          r_rd_pending;
  logic          r_rd_master;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic          w_win_valid;
  logic          w_winner;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;
  logic          w_win_we;
  logic          w_win_lock;
  logic          w_same_owner;
  logic [BW-1:0] w_burst_nxt;

  rr_pick2 #(
    .MAX_BURST (MAX_BURST),
    .BW        (BW)
  ) u_pick (
    .i_req        ({m1_req, m0_req}),
    .i_lock_owner (r_lock_owner),
    .i_burst_cnt  (r_burst_cnt),
    .i_last_grant (r_last_grant),
    .o_valid      (w_win_valid),
    .o_winner     (w_winner)
  );

  assign w_win_addr  = w_winner ? m1_addr  : m0_addr;
  assign w_win_wdata = w_winner ? m1_wdata : m0_wdata;
  assign w_win_we    = w_winner ? m1_we    : m0_we;
  assign w_win_lock  = w_winner ? m1_lock  : m0_lock;

  // Burst counting continues only while the same master re-wins on a held lock.
  assign w_same_owner = (r_lock_owner == id_to_master(w_winner));
  assign w_burst_nxt  = !w_same_owner                        ? BW'(1) :
                        (r_burst_cnt == BW'(MAX_BURST))      ? r_burst_cnt :
                                                               r_burst_cnt + BW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
      r_lock_owner <= NONE;
      r_burst_cnt  <= '0;
      r_rd_pending <= 1'b0;
      r_rd_master  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else if (w_win_valid) begin
      r_last_grant <= w_winner;
      r_lock_owner <= w_win_lock ? id_to_master(w_winner) : NONE;
      r_burst_cnt  <= w_burst_nxt;
      r_rd_pending <= ~w_win_we;
      r_rd_master  <= w_winner;
      r_mem_addr   <= w_win_addr;
      r_mem_wdata  <= w_win_wdata;
    end else begin
      r_rd_pending <= 1'b0;
    end
  end

  always_comb begin
    memAddr   = r_mem_addr;
    memWrite  = r_mem_wdata;
    memWE     = 1'b0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = r_rd_pending & ~r_rd_master;
    m1_rvalid = r_rd_pending &  r_rd_master;
    m0_rdata  = m0_rvalid ? memRead : '0;
    m1_rdata  = m1_rvalid ? memRead : '0;
    if (w_win_valid) begin
      memAddr  = w_win_addr;
      memWrite = w_win_wdata;
      memWE    = w_win_we;
      m0_gnt   = ~w_winner;
      m1_gnt   = w_winner;
    end
    // Reset overrides everything, including combinational grants from live requests.
    if (!rst) begin
      memAddr   = '0;
      memWrite  = '0;
      memWE     = 1'b0;
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      m0_rdata  = '0;
      m1_rdata  = '0;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 16-bit RAM port between two requesters: master 0 (CPU data/fetch port) and master 1 (DMA/loader/debug port).
- Issues at most one memory access per cycle.
- Arbitration is round-robin, with an optional bounded lock for bursts.
- Returns read data one cycle after issue with a per-master valid strobe.
- Sits between rcpu/peripheral masters and the RAM block.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MAX_BURST, 4, maximum consecutive grants to one master while it holds lock and the other master is requesting (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 access request; held with addr/wdata/we/lock stable until m0_gnt.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_we  in  1  master 0 write enable (1 = write, 0 = read).
- m0_lock  in  1  master 0 requests to keep ownership for its next access.
- m0_gnt  out  1  access issued for master 0 this cycle.
- m0_rdata  out  DW  master 0 read data, valid with m0_rvalid.
- m0_rvalid  out  1  read data for master 0's previous-cycle read.
- m1_req, m1_addr, m1_wdata, m1_we, m1_lock, m1_gnt, m1_rdata, m1_rvalid: same as master 0, for master 1.
- memAddr  out  AW  RAM address.
- memRead  in  DW  RAM read data; valid one cycle after the address is presented.
- memWrite  out  DW  RAM write data.
- memWE  out  1  RAM write enable.

Behaviour:
- Reset (rst low, async):
  - last_grant = 1, so master 0 wins the first tie.
  - owner lock cleared; burst_cnt = 0.
  - rd_pending = 0, rd_master = 0.
  - All gnt/rvalid = 0; memWE = 0; memAddr = 0; memWrite = 0.
  - Outputs are forced to these values combinationally while rst is low.
- Grant decision (combinational from req and registered state, same cycle):
  - If locked_owner is valid and that master requests, it wins, unless burst_cnt == MAX_BURST and the other master requests; then the other master wins.
  - Otherwise, if only one master requests, it wins.
  - If both request, the master != last_grant wins.
  - If neither requests: no gnt, memWE = 0, memAddr/memWrite hold their last issued values.
- Issue: the winner's addr/wdata drive memAddr/memWrite; memWE = winner_we; the winner's gnt = 1. Exactly one gnt is high at a time, never both.
- Registered on every grant:
  - last_grant <= winner.
  - rd_pending <= ~winner_we; rd_master <= winner.
  - Lock: if winner_lock, locked_owner <= winner, else locked_owner cleared.
  - burst_cnt <= (winner == previous locked_owner) ? burst_cnt+1 (saturating at MAX_BURST) : 1.
- With no grant: rd_pending <= 0, locked_owner is retained, burst_cnt is unchanged.
- Read return: in the cycle after a read grant, mX_rvalid = 1 for rd_master only, and mX_rdata = memRead.
  - rdata of the non-selected master is 0.
  - Write grants never produce rvalid.
- Back-to-back reads to alternating masters each get their rvalid on the following cycle. Pipelined; throughput 1 access/cycle.
- Lock with the other master idle: no limit, and burst_cnt saturates.
- Lock dropped by the owner, or the owner stops requesting: normal round-robin applies immediately, i.e. the other master is eligible in the same cycle.
- Reset asserted mid-read: the pending rvalid is discarded and not delivered after reset release.
- Requester deasserting req without gnt is legal: the request is withdrawn and no state changes.

Decomposition:
- Shared package/header: AW/DW defaults, master-ID constants (M0 = 0, M1 = 1, NONE).
- One natural sub-module, rr_pick2: 2-way round-robin priority pick with lock override and burst limit, purely combinational. Returns winner and valid.
- Datapath muxing and the read-return pipeline register stay in mem_arbiter.

Test Plan:
- Reset then m0 read 0x0010 (RAM[0x10] = 0x1234) -> m0_gnt same cycle, memAddr = 0x0010, next cycle m0_rvalid = 1 and m0_rdata = 0x1234, m1_rvalid = 0.
- Both request every cycle, no lock, m0 read 0x0001, m1 write 0x0002 <= 0xBEEF -> grants alternate m0, m1, m0, ... starting with m0; RAM[2] = 0xBEEF; m0_rvalid only in cycles following m0 grants.
- m1 lock held with 6 reads queued while m0 requests continuously, MAX_BURST = 4 -> m1 granted 4 consecutive cycles, then m0 granted once, then m1 resumes.
- m0 lock held with m1 idle for 10 cycles -> m0 granted all 10 cycles, no forced switch.
- m0 read granted, rst pulsed low on the next rising edge -> no m0_rvalid after release; all outputs 0 during reset; first post-reset tie goes to m0.
- m1 raises req for 1 cycle while m0 holds a locked burst with burst_cnt < MAX_BURST, then withdraws -> m1 never granted, m0 continues uninterrupted, memWE follows m0_we only.
